// File: rtl/snn_if.sv
// Handshake/bus bundle between the input-neuron stage, the SNN core and the
// downstream decision logic.
interface snn_if #(
  parameter int INPUTNUM = 4,
  parameter int EXCNUM   = 2,
  parameter int DW       = 16,
  parameter int CNTW     = 10,
  parameter int AW       = (INPUTNUM * EXCNUM > 1) ? $clog2(INPUTNUM * EXCNUM) : 1
);
  logic                     en;
  logic                     step;
  logic [INPUTNUM-1:0]      pre_spike;
  logic                     w_we;
  logic [AW-1:0]            w_addr;
  logic signed [DW-1:0]     w_data;
  logic [EXCNUM-1:0]        out_spike;
  logic                     spike_valid;
  logic [EXCNUM*CNTW-1:0]   spike_cnt;
  logic                     cnt_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output en, step, pre_spike, w_we, w_addr, w_data,
    input  out_spike, spike_valid, spike_cnt, cnt_valid, busy, overrun
  );

  modport slave (
    input  en, step, pre_spike, w_we, w_addr, w_data,
    output out_spike, spike_valid, spike_cnt, cnt_valid, busy, overrun
  );
endinterface

// File: rtl/snn_core.sv
// Spiking-network core: weight register file, single-MAC time-multiplexed
// accumulation, saturating leaky integrate-and-fire neurons, windowed counters.
module snn_core #(
  parameter int                   INPUTNUM   = 4,
  parameter int                   EXCNUM     = 2,
  parameter int                   DW         = 16,
  parameter logic signed [DW-1:0] THRESH     = 16'sd8192,
  parameter int                   LEAK_SHIFT = 4,
  parameter int                   CNTW       = 10,
  parameter int                   WINDOW     = 1000
) (
  input  logic clk,
  input  logic rst,
  snn_if.slave bus
);

  localparam int NM   = INPUTNUM * EXCNUM;
  localparam int AW   = (NM > 1) ? $clog2(NM) : 1;
  localparam int IW   = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1;
  localparam int JW   = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;
  localparam int ACCW = DW + $clog2(INPUTNUM) + 1;
  localparam int VW   = ((ACCW > DW) ? ACCW : DW) + 2;
  localparam int WINW = $clog2(WINDOW + 1);

  localparam logic signed [DW-1:0] VMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] VMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_e;

  state_e                   state_q, state_d;
  logic [INPUTNUM-1:0]      ps_q;
  logic [AW-1:0]            k_q;
  logic [IW-1:0]            i_q;
  logic [JW-1:0]            j_q;
  logic signed [DW-1:0]     w_q   [NM];
  logic signed [ACCW-1:0]   acc_q [EXCNUM];
  logic signed [DW-1:0]     v_q   [EXCNUM];
  logic [CNTW-1:0]          cnt_q [EXCNUM];
  logic [WINW-1:0]          win_q;
  logic [EXCNUM-1:0]        out_spike_q;
  logic                     spike_valid_q;
  logic [EXCNUM*CNTW-1:0]   spike_cnt_q;
  logic                     cnt_valid_q;
  logic                     overrun_q;

  logic                     accept, accum_en, fire_en, busy, wr_en, win_last;
  logic signed [ACCW-1:0]   add_term;
  logic signed [VW-1:0]     v_full [EXCNUM];
  logic signed [DW-1:0]     v_new  [EXCNUM];
  logic [CNTW-1:0]          cnt_nxt [EXCNUM];
  logic [EXCNUM-1:0]        fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    accum_en = 1'b0;
    fire_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.step && bus.en) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        accum_en = 1'b1;
        if (k_q == AW'(NM - 1)) state_d = FIRE;
      end
      FIRE: begin
        fire_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign wr_en    = bus.w_we && !busy && ({1'b0, bus.w_addr} < (AW + 1)'(NM));
  assign add_term = ps_q[i_q] ? ACCW'(w_q[k_q]) : '0;
  assign win_last = (win_q == WINW'(WINDOW - 1));

  // Membrane update is evaluated in full precision, then clamped to DW.
  always_comb begin
    for (int j = 0; j < EXCNUM; j++) begin
      v_full[j] = VW'(v_q[j]) - VW'(v_q[j] >>> LEAK_SHIFT) + VW'(acc_q[j]);
      if (v_full[j] > VW'(VMAX))      v_new[j] = VMAX;
      else if (v_full[j] < VW'(VMIN)) v_new[j] = VMIN;
      else                            v_new[j] = v_full[j][DW-1:0];
      fire[j]    = (v_new[j] >= THRESH);
      cnt_nxt[j] = (fire[j] && (cnt_q[j] != {CNTW{1'b1}})) ? cnt_q[j] + 1'b1 : cnt_q[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NM; n++) w_q[n] <= '0;
    end else if (wr_en) begin
      w_q[bus.w_addr] <= bus.w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
      k_q  <= '0;
      i_q  <= '0;
      j_q  <= '0;
      for (int j = 0; j < EXCNUM; j++) acc_q[j] <= '0;
    end else if (accept) begin
      ps_q <= bus.pre_spike;
      k_q  <= '0;
      i_q  <= '0;
      j_q  <= '0;
      for (int j = 0; j < EXCNUM; j++) acc_q[j] <= '0;
    end else if (accum_en) begin
      acc_q[j_q] <= acc_q[j_q] + add_term;
      k_q        <= k_q + 1'b1;
      if (i_q == IW'(INPUTNUM - 1)) begin
        i_q <= '0;
        j_q <= j_q + 1'b1;
      end else begin
        i_q <= i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < EXCNUM; j++) begin
        v_q[j]   <= '0;
        cnt_q[j] <= '0;
      end
      win_q         <= '0;
      out_spike_q   <= '0;
      spike_valid_q <= 1'b0;
      spike_cnt_q   <= '0;
      cnt_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      spike_valid_q <= fire_en;
      cnt_valid_q   <= 1'b0;
      overrun_q     <= busy && ((bus.step && bus.en) || bus.w_we);
      if (fire_en) begin
        out_spike_q <= fire;
        for (int j = 0; j < EXCNUM; j++) v_q[j] <= fire[j] ? '0 : v_new[j];
        // The window closes on this step, so its spikes land in the latched copy.
        if (win_last) begin
          for (int j = 0; j < EXCNUM; j++) begin
            spike_cnt_q[j*CNTW +: CNTW] <= cnt_nxt[j];
            cnt_q[j]                    <= '0;
          end
          win_q       <= '0;
          cnt_valid_q <= 1'b1;
        end else begin
          for (int j = 0; j < EXCNUM; j++) cnt_q[j] <= cnt_nxt[j];
          win_q <= win_q + 1'b1;
        end
      end
    end
  end

  assign bus.out_spike   = out_spike_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_cnt   = spike_cnt_q;
  assign bus.cnt_valid   = cnt_valid_q;
  assign bus.busy        = busy;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_snn_core.sv
// Directed + randomized bench for snn_core (N=4, M=2, WINDOW=4) against an
// arithmetic reference model of the network timestep.
module tb_snn_core;
  localparam int N      = 4;
  localparam int M      = 2;
  localparam int WIN    = 4;
  localparam int THR    = 8192;
  localparam int LAT    = N * M + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  snn_if #(.INPUTNUM(N), .EXCNUM(M), .DW(16), .CNTW(10)) bus ();
  snn_core #(.INPUTNUM(N), .EXCNUM(M), .DW(16), .THRESH(16'sd8192),
             .LEAK_SHIFT(4), .CNTW(10), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int         w_m  [N*M];
  int         v_m  [M];
  int         rc_m [M];
  int         win_m;
  logic [19:0] cnt_lat_m;
  logic [1:0]  out_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N*M; n++) w_m[n] = 0;
    for (int j = 0; j < M; j++) begin v_m[j] = 0; rc_m[j] = 0; end
    win_m = 0; cnt_lat_m = '0; out_m = '0;
  endtask

  task automatic model_step(input logic [N-1:0] ps, output logic cv);
    int acc, vp;
    for (int j = 0; j < M; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) if (ps[i]) acc += w_m[j*N + i];
      vp = v_m[j] - (v_m[j] >>> 4) + acc;
      if (vp > 32767) vp = 32767;
      if (vp < -32768) vp = -32768;
      out_m[j] = (vp >= THR);
      v_m[j]   = out_m[j] ? 0 : vp;
      if (out_m[j] && rc_m[j] < 1023) rc_m[j]++;
    end
    win_m++;
    cv = (win_m == WIN);
    if (cv) begin
      for (int j = 0; j < M; j++) begin
        cnt_lat_m[j*10 +: 10] = 10'(rc_m[j]);
        rc_m[j] = 0;
      end
      win_m = 0;
    end
  endtask

  task automatic write_w(input int addr, input int data);
    @(negedge clk);
    bus.w_we = 1'b1; bus.w_addr = 3'(addr); bus.w_data = 16'(data);
    w_m[addr] = 32'(signed'(16'(data)));
    @(negedge clk);
    bus.w_we = 1'b0;
  endtask

  // One timestep; inject=1 fires a dropped write and a dropped step mid-flight.
  task automatic run_step(input logic [N-1:0] ps, input bit inject,
                          input bit wr_too, input int waddr, input int wdata);
    logic cv;
    int   lat;
    bit   done;
    @(negedge clk);
    bus.step = 1'b1; bus.en = 1'b1; bus.pre_spike = ps;
    if (wr_too) begin
      bus.w_we = 1'b1; bus.w_addr = 3'(waddr); bus.w_data = 16'(wdata);
      w_m[waddr] = 32'(signed'(16'(wdata)));
    end
    @(negedge clk);
    bus.step = 1'b0; bus.w_we = 1'b0;
    chk("busy_rise", bus.busy, 1);
    model_step(ps, cv);
    lat = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (inject) begin
        case (lat)
          2: begin bus.w_we = 1'b1; bus.w_addr = 3'd0; bus.w_data = 16'sd12345; end
          3: begin bus.w_we = 1'b0; chk("ovr_write", bus.overrun, 1); end
          4: begin chk("ovr_clear1", bus.overrun, 0); bus.step = 1'b1; end
          5: begin bus.step = 1'b0; chk("ovr_step", bus.overrun, 1); end
          6: chk("ovr_clear2", bus.overrun, 0);
          default: ;
        endcase
      end
      if (bus.spike_valid) done = 1;
    end
    chk("latency", lat, LAT);
    chk("out_spike", bus.out_spike, out_m);
    chk("cnt_valid", bus.cnt_valid, cv);
    chk("spike_cnt", bus.spike_cnt, cnt_lat_m);
    chk("busy_fall", bus.busy, 0);
    @(negedge clk);
    chk("sv_pulse", {bus.spike_valid, bus.cnt_valid}, 2'b00);
  endtask

  initial begin
    logic [1:0] hold;
    bit         extra;
    rst = 1'b1;
    bus.en = 1'b0; bus.step = 1'b0; bus.pre_spike = '0;
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.out_spike, bus.spike_valid, bus.spike_cnt, bus.cnt_valid,
                     bus.busy, bus.overrun}, '0);
    rst = 1'b0;

    // Leak vs input: neuron 1 fires every step, neuron 0 every second step.
    write_w(0, 5000);
    write_w(4, 9000);
    run_step(4'b0001, 0, 0, 0, 0);
    chk("first_out", bus.out_spike, 2'b10);
    for (int s = 0; s < 3; s++) run_step(4'b0001, 0, 0, 0, 0);
    chk("window_cnt", bus.spike_cnt, {10'd4, 10'd2});

    // Positive then negative saturation, then recovery from the clamped floor.
    for (int a = 0; a < N; a++) write_w(a, 32767);
    run_step(4'b1111, 0, 0, 0, 0);
    for (int a = 0; a < N; a++) write_w(a, -32768);
    run_step(4'b1111, 0, 0, 0, 0);
    for (int a = 1; a < N; a++) write_w(a, 0);
    write_w(0, 30000);
    run_step(4'b0001, 0, 0, 0, 0);
    chk("neg_floor", bus.out_spike[0], 0);
    run_step(4'b0001, 0, 0, 0, 0);
    chk("recover", bus.out_spike[0], 1);

    // Requests while busy are dropped and flagged; no phantom timestep follows.
    run_step(4'b0001, 1, 0, 0, 0);
    hold = bus.out_spike; extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.spike_valid || bus.busy || bus.out_spike !== hold) extra = 1;
    end
    chk("no_extra", extra, 0);
    chk("held_out", hold, out_m);

    // Write and step together: the step sees the new weight.
    run_step(4'b0001, 0, 1, 4, -20000);
    chk("wr_step_n1", bus.out_spike[1], 0);

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 1) == 1)
        write_w($urandom_range(0, N*M-1), int'($urandom_range(0, 65535)) - 32768);
      run_step(4'($urandom_range(0, 15)), 0, 0, 0, 0);
    end

    // Asynchronous reset in the middle of accumulation.
    @(negedge clk);
    bus.step = 1'b1; bus.en = 1'b1; bus.pre_spike = 4'hF;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async", {bus.out_spike, bus.spike_valid, bus.spike_cnt, bus.cnt_valid,
                         bus.busy, bus.overrun}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_step(4'hF, 0, 0, 0, 0);
    chk("post_rst_out", bus.out_spike, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
